// File: rtl/addr_gather.sv
// Strided gather: issues LANES reads at base + k*stride to a single-port RAM
// and packs the returned words into lane_data, pulsing done when complete.
module addr_gather #(
  parameter int AW         = 12,
  parameter int DW         = 8,
  parameter int LANES      = 4,
  parameter int STRIDE     = 9,
  parameter int RD_LAT     = 1,
  parameter int HALT_ADDR  = 4091,
  parameter int NOP_OPCODE = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [5:0]            instr_fb,
  output logic                  mem_rd_en,
  output logic [AW-1:0]         mem_addr,
  input  logic [DW-1:0]         mem_rdata,
  output logic [LANES*DW-1:0]   lane_data,
  output logic                  busy,
  output logic                  done
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state;
  logic [AW-1:0]     stride_q;
  logic [AW-1:0]     eff_stride;
  logic [IW-1:0]     iss_idx;
  logic [IW-1:0]     cap_idx;
  logic [RD_LAT-1:0] rd_pipe;
  logic              cap_valid;
  logic              cap_last;

  // Only the resolved stride is kept; base and opcode matter solely at accept.
  always_comb begin
    eff_stride = AW'(STRIDE);
    if (instr_fb == 6'(NOP_OPCODE) || base_addr == AW'(HALT_ADDR))
      eff_stride = '0;
  end

  always_comb begin
    cap_valid = rd_pipe[RD_LAT-1];
    cap_last  = cap_valid && (cap_idx == IW'(LANES-1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      lane_data <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stride_q  <= '0;
      iss_idx   <= '0;
      cap_idx   <= '0;
      rd_pipe   <= '0;
    end else begin
      // Capture runs off a delayed copy of the read strobe, independent of issue.
      rd_pipe[0] <= mem_rd_en;
      for (int unsigned i = 1; i < RD_LAT; i++)
        rd_pipe[i] <= rd_pipe[i-1];

      if (cap_valid) begin
        lane_data[cap_idx*DW +: DW] <= mem_rdata;
        cap_idx <= cap_idx + 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            mem_rd_en <= 1'b1;
            mem_addr  <= base_addr;
            stride_q  <= eff_stride;
            iss_idx   <= '0;
            cap_idx   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (iss_idx == IW'(LANES-1)) begin
            mem_rd_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            mem_addr <= mem_addr + stride_q;
            iss_idx  <= iss_idx + 1'b1;
          end
        end
        DRAIN: begin
          state <= DRAIN;
        end
        default: state <= IDLE;
      endcase

      if (cap_last) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  end

endmodule
